mul8_rr_arbiter: RTL and testbench

Shares one 8-bit M-extension multiplier (signed_mul_4to2_tree_8bit) between NREQ requesters.
- Arbitrates requests round-robin and registers the winner's func3/op1/op2 into the multiplier.
- Tracks in-flight operations in a MUL_LAT-deep tag pipeline.
- Returns each 16-bit result to its requester through a per-requester response FIFO, using credit-based flow control.
- Sits between the issue logic and the multiplier datapath. Sustains one issue per cycle.

---
 rtl/mul8_pkg.sv | 28 ++
 rtl/mul8_rsp_fifo.sv | 80 ++++++++
 rtl/mul8_rr_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mul8_rr_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8_pkg.sv
// Shared types and constants for the shared 8-bit multiplier arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mul8_pkg;

    // Requester ids are sized for the largest supported NREQ (4).
    localparam int MAX_NREQ = 4;
    localparam int ID_W     = $clog2(MAX_NREQ);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    // One in-flight operation travelling alongside the multiplier.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } mul_tag_t;

    // One buffered response.
    typedef struct packed {
        logic [15:0] result;
        logic        err;
    } rsp_entry_t;

endpackage

// File: rtl/mul8_rsp_fifo.sv
// Response FIFO for one requester; head is registered, no write-to-read bypass.
// Latency: push at edge N is visible at head (empty=0) from cycle N+1.
// Backpressure: push is accepted when not full or when popping the same edge.
// Ports: push/push_dat write the tail, pop removes the head, head_dat is the
// head entry (zero when empty), full/empty/count report occupancy.
module mul8_rsp_fifo
    import mul8_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  rsp_entry_t       push_dat,
    input  logic             pop,
    output rsp_entry_t       head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t       mem_q [DEPTH];
    rsp_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot on the same edge, so push-at-full is fine with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mul8_rr_arbiter.sv
// Round-robin share of one 8-bit multiplier among NREQ requesters with per-requester response FIFOs.
// Latency: issue in T -> operands on mul_* in T+1 -> rsp_valid in T+2+MUL_LAT.
// Backpressure: credit per requester (= RSP_DEPTH); req_ready stays low while that requester has no credit.
// Ports: req_* issue side (valid/ready, flat per-requester func3/op1/op2),
// rsp_* response side (valid/ready, result, err), mul_* drive the external
// multiplier and mul_result returns its product.
module mul8_rr_arbiter
    import mul8_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MUL_LAT   = 1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*3-1:0]    req_func3,
    input  logic [NREQ*8-1:0]    req_op1,
    input  logic [NREQ*8-1:0]    req_op2,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*16-1:0]   rsp_result,
    output logic [NREQ-1:0]      rsp_err,
    output logic                 mul_rst_n,
    output logic [2:0]           mul_func3,
    output logic [7:0]           mul_op1,
    output logic [7:0]           mul_op2,
    input  logic [15:0]          mul_result
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CRD_W = $clog2(RSP_DEPTH + 1);

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [CRD_W-1:0] credit_q [NREQ];
    logic [CRD_W-1:0] credit_d [NREQ];
    mul_tag_t         tag_q [MUL_LAT+1];
    mul_tag_t         tag_d [MUL_LAT+1];
    logic [2:0]       mul_func3_q, mul_func3_d;
    logic [7:0]       mul_op1_q, mul_op1_d;
    logic [7:0]       mul_op2_q, mul_op2_d;

    logic [NREQ-1:0]  eligible, grant, rsp_pop, fifo_push, fifo_full, fifo_empty;
    logic [IDX_W-1:0] grant_id;
    logic             issue;
    logic [2:0]       sel_func3;
    logic [7:0]       sel_op1, sel_op2;
    mul_tag_t         wb_tag;
    rsp_entry_t       wb_entry;
    rsp_entry_t       fifo_head [NREQ];
    logic [CRD_W-1:0] fifo_cnt_unused [NREQ];

    // The full term is redundant with the credit check; it keeps a FIFO
    // from ever being over-committed should credits be disturbed.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_valid[i] && (credit_q[i] != '0) && !fifo_full[i] && !rst;
        end
    end

    // Search upward from last_grant+1 with wrap; first eligible wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_grant_q) + k) % NREQ;
            if (grant == '0 && eligible[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDX_W'(idx);
            end
        end
    end

    assign req_ready    = grant;
    assign issue        = |grant;
    assign sel_func3    = req_func3[int'(grant_id)*3 +: 3];
    assign sel_op1      = req_op1[int'(grant_id)*8 +: 8];
    assign sel_op2      = req_op2[int'(grant_id)*8 +: 8];
    assign last_grant_d = issue ? grant_id : last_grant_q;

    // Illegal func3 (1xx) and idle cycles present all-zero operands.
    always_comb begin
        mul_func3_d = '0;
        mul_op1_d   = '0;
        mul_op2_d   = '0;
        if (issue && !sel_func3[2]) begin
            mul_func3_d = sel_func3;
            mul_op1_d   = sel_op1;
            mul_op2_d   = sel_op2;
        end
    end

    // Tag stage s is live in cycle T+1+s; stage MUL_LAT lines up with mul_result.
    always_comb begin
        tag_d[0] = '0;
        if (issue) begin
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = ID_W'(grant_id);
            tag_d[0].err   = sel_func3[2];
        end
        for (int s = 1; s <= MUL_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    assign wb_tag = tag_q[MUL_LAT];

    always_comb begin
        wb_entry = '0;
        if (wb_tag.err) begin
            wb_entry.err = 1'b1;
        end else begin
            wb_entry.result = mul_result;
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            fifo_push[i] = wb_tag.valid && (wb_tag.id == ID_W'(i));
            rsp_pop[i]   = rsp_valid[i] && rsp_ready[i];
        end
    end

    // Issue and pop on the same requester in one cycle cancel out.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            credit_d[i] = credit_q[i];
            if (grant[i] && !rsp_pop[i]) begin
                credit_d[i] = credit_q[i] - CRD_W'(1);
            end else if (!grant[i] && rsp_pop[i]) begin
                credit_d[i] = credit_q[i] + CRD_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_rsp
        mul8_rsp_fifo #(
            .DEPTH (RSP_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (fifo_push[g]),
            .push_dat (wb_entry),
            .pop      (rsp_pop[g]),
            .head_dat (fifo_head[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g]),
            .count    (fifo_cnt_unused[g])
        );
        assign rsp_valid[g]            = !fifo_empty[g];
        assign rsp_result[g*16 +: 16]  = fifo_head[g].result;
        assign rsp_err[g]              = fifo_head[g].err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Pointing at the last requester gives requester 0 top priority.
            last_grant_q <= IDX_W'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                credit_q[i] <= CRD_W'(RSP_DEPTH);
            end
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
            mul_func3_q <= '0;
            mul_op1_q   <= '0;
            mul_op2_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            credit_q     <= credit_d;
            tag_q        <= tag_d;
            mul_func3_q  <= mul_func3_d;
            mul_op1_q    <= mul_op1_d;
            mul_op2_q    <= mul_op2_d;
        end
    end

    assign mul_rst_n = ~rst;
    assign mul_func3 = mul_func3_q;
    assign mul_op1   = mul_op1_q;
    assign mul_op2   = mul_op2_q;

endmodule

// File: tb/tb_mul8_rr_arbiter.sv
// Bench for mul8_rr_arbiter: directed scenarios plus random traffic, scoreboard checked.
// Latency: n/a.
// Backpressure: rsp_ready driven directly and randomly.
module tb_mul8_rr_arbiter;
    import mul8_pkg::*;

    localparam int NREQ      = 2;
    localparam int MUL_LAT   = 1;
    localparam int RSP_DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [NREQ*3-1:0]   req_func3;
    logic [NREQ*8-1:0]   req_op1, req_op2;
    logic [NREQ*16-1:0]  rsp_result;
    logic                mul_rst_n;
    logic [2:0]          mul_func3;
    logic [7:0]          mul_op1, mul_op2;
    logic [15:0]         mul_result;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul8_rr_arbiter #(
        .NREQ      (NREQ),
        .MUL_LAT   (MUL_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func3  (req_func3),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mul_rst_n  (mul_rst_n),
        .mul_func3  (mul_func3),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_result (mul_result)
    );

    // Full 16-bit product with the signedness each func3 selects.
    function automatic logic [15:0] ref_prod(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b);
        int sa, sb_, p;
        sa  = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb_ = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        case (f3)
            3'b000, 3'b001: p = sa * sb_;
            3'b010:         p = sa * int'(b);
            3'b011:         p = int'(a) * int'(b);
            default:        p = 0;
        endcase
        return p[15:0];
    endfunction

    // Stand-in for the external single-cycle multiplier.
    always @(posedge clk) begin
        if (!mul_rst_n) mul_result <= '0;
        else            mul_result <= ref_prod(mul_func3, mul_op1, mul_op2);
    end

    function automatic int outstanding(input int id);
        int n;
        n = 0;
        foreach (sb[k]) if (sb[k].id == id) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: arbitration model, multiplier-drive model and response scoreboard.
    logic [2:0] e_f3 = '0;
    logic [7:0] e_a  = '0;
    logic [7:0] e_b  = '0;
    int         m_last = NREQ - 1;

    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_gnt;
        logic [2:0]      f3;
        logic [7:0]      a, b;
        exp_t            e;
        int              j;
        bit              nrst, lat_ok;
        if (chk_en) begin
            nrst = ~rst;
            check("mul_rst_n", mul_rst_n, nrst);
            check("mul_func3", mul_func3, e_f3);
            check("mul_op1", mul_op1, e_a);
            check("mul_op2", mul_op2, e_b);
            if (rst) begin
                check("ready_in_rst", req_ready, '0);
                sb.delete();
                m_last = NREQ - 1;
                e_f3 = '0; e_a = '0; e_b = '0;
            end else begin
                exp_gnt = '0;
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (exp_gnt == '0 && req_valid[idx] && outstanding(idx) < RSP_DEPTH)
                        exp_gnt[idx] = 1'b1;
                end
                check("grant", req_ready, exp_gnt);
                e_f3 = '0; e_a = '0; e_b = '0;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        f3 = req_func3[i*3 +: 3];
                        a  = req_op1[i*8 +: 8];
                        b  = req_op2[i*8 +: 8];
                        m_last = i;
                        e.id  = i;
                        e.err = f3[2];
                        e.res = f3[2] ? 16'h0000 : ref_prod(f3, a, b);
                        e.cyc = cyc;
                        sb.push_back(e);
                        if (!f3[2]) begin
                            e_f3 = f3; e_a = a; e_b = b;
                        end
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (rsp_valid[i]) begin
                        j = -1;
                        foreach (sb[k]) if (j < 0 && sb[k].id == i) j = k;
                        if (j < 0) begin
                            check("rsp_valid_no_pending", rsp_valid[i], 1'b0);
                        end else if (rsp_ready[i]) begin
                            check("rsp_result", rsp_result[i*16 +: 16], sb[j].res);
                            check("rsp_err", rsp_err[i], sb[j].err);
                            lat_ok = (cyc - sb[j].cyc) >= 2 + MUL_LAT;
                            check("rsp_too_early", lat_ok, 1'b1);
                            sb.delete(j);
                        end
                    end else begin
                        check("idle_result", rsp_result[i*16 +: 16], '0);
                        check("idle_err", rsp_err[i], 1'b0);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        tick();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    // One request from requester id with exact timing checks.
    task automatic single(input int id, input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_res, input logic exp_err);
        logic [NREQ-1:0] oh;
        int lat;
        oh = '0;
        oh[id] = 1'b1;
        tick();
        req_valid = oh;
        req_func3[id*3 +: 3] = f3;
        req_op1[id*8 +: 8] = a;
        req_op2[id*8 +: 8] = b;
        @(negedge clk);
        check("single_ready", req_ready, oh);
        tick();
        req_valid = '0;
        check("single_mul_f3", mul_func3, exp_err ? 3'b000 : f3);
        check("single_mul_op1", mul_op1, exp_err ? 8'h00 : a);
        check("single_mul_op2", mul_op2, exp_err ? 8'h00 : b);
        lat = 1;
        while (!rsp_valid[id] && lat < 12) begin
            tick();
            lat++;
        end
        check("single_latency", lat, 2 + MUL_LAT);
        check("single_result", rsp_result[id*16 +: 16], exp_res);
        check("single_err", rsp_err[id], exp_err);
        check("single_other_quiet", rsp_valid & ~oh, '0);
    endtask

    initial begin
        int lat, cnt, cnt0, cnt1;
        logic [NREQ-1:0] e;
        rst       = 1'b1;
        req_valid = '0;
        req_func3 = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = '1;
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_rsp_valid", rsp_valid, '0);
        check("reset_rsp_result", rsp_result, '0);
        check("reset_mul_op1", mul_op1, '0);

        // MUL -3 * 5, then an illegal func3.
        single(0, 3'b000, 8'hFD, 8'h05, 16'hFFF1, 1'b0);
        single(0, 3'b100, 8'h12, 8'h34, 16'h0000, 1'b1);

        // Back-to-back on requester 1: MULHU then MULHSU, in order.
        tick();
        req_valid = 2'b10;
        req_func3[5:3] = 3'b011; req_op1[15:8] = 8'hFF; req_op2[15:8] = 8'hFF;
        @(negedge clk);
        check("b2b_ready0", req_ready, 2'b10);
        tick();
        req_func3[5:3] = 3'b010; req_op1[15:8] = 8'h80; req_op2[15:8] = 8'h02;
        @(negedge clk);
        check("b2b_ready1", req_ready, 2'b10);
        tick();
        req_valid = '0;
        lat = 2;
        while (!rsp_valid[1] && lat < 12) begin
            tick();
            lat++;
        end
        check("b2b_latency", lat, 3);
        check("b2b_first", rsp_result[31:16], 16'hFE01);
        tick();
        check("b2b_second_valid", rsp_valid[1], 1'b1);
        check("b2b_second", rsp_result[31:16], 16'hFF00);
        repeat (4) tick();

        // Both requesters always valid: strict alternation from reset.
        apply_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_func3[i*3 +: 3] = 3'($urandom_range(0, 3));
                req_op1[i*8 +: 8]   = 8'($urandom);
                req_op2[i*8 +: 8]   = 8'($urandom);
            end
            @(negedge clk);
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("alt_grant", req_ready, e);
            tick();
        end
        req_valid = '0;
        repeat (6) tick();

        // Credit exhaustion on requester 0, then one pop buys one issue.
        apply_reset();
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        req_func3[2:0] = 3'b000;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (req_ready[0]) cnt++;
            tick();
        end
        check("credit_issues", cnt, RSP_DEPTH);
        rsp_ready = 2'b11;
        cnt = 0;
        @(negedge clk);
        if (req_ready[0]) cnt++;
        tick();
        rsp_ready = 2'b10;
        repeat (8) begin
            @(negedge clk);
            if (req_ready[0]) cnt++;
            tick();
        end
        check("credit_one_more", cnt, 1);
        req_valid = '0;
        rsp_ready = '1;
        repeat (8) tick();

        // Reset with two ops in flight and one buffered.
        rsp_ready = '0;
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 2'b01;
        tick();
        tick();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", req_ready, '0);
        tick();
        rst = 1'b0;
        check("midrst_valid", rsp_valid, '0);
        rsp_ready = '1;
        repeat (10) begin
            tick();
            check("midrst_quiet", rsp_valid, '0);
        end
        rsp_ready = '0;
        req_valid = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready[0]) cnt0++;
            if (req_ready[1]) cnt1++;
            tick();
        end
        check("midrst_credit0", cnt0, RSP_DEPTH);
        check("midrst_credit1", cnt1, RSP_DEPTH);
        req_valid = '0;
        rsp_ready = '1;
        repeat (8) tick();

        // Random traffic with occasional resets.
        repeat (3000) begin
            tick();
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) req_func3[i*3 +: 3] = 3'($urandom_range(4, 7));
                else                           req_func3[i*3 +: 3] = 3'($urandom_range(0, 3));
                req_op1[i*8 +: 8] = 8'($urandom);
                req_op2[i*8 +: 8] = 8'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
        end
        tick();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        repeat (12) tick();
        @(negedge clk);
        check("drain_pending", sb.size(), 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
